// File: rtl/nic_pkg.sv
// Shared constants for the NIC: PE register addresses and status word bit positions.
package nic_pkg;

    typedef enum logic [1:0] {
        ADDR_IN_DATA  = 2'b00,
        ADDR_IN_STAT  = 2'b01,
        ADDR_OUT_DATA = 2'b10,
        ADDR_OUT_STAT = 2'b11
    } nic_addr_e;

    localparam int STAT_FLAG0   = 0;
    localparam int STAT_FLAG1   = 1;
    localparam int STAT_CNT_LSB = 8;
    localparam int STAT_ERR0    = 16;
    localparam int STAT_ERR1    = 17;

    // Width needed to hold an occupancy count of 0..depth
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/nic_sync_fifo.sv
// Synchronous FIFO with combinational head, occupancy count and modulo-DEPTH pointers.
module nic_sync_fifo
    import nic_pkg::*;
#(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 wdata,
    output logic [W-1:0]                 rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // Full/empty are judged on the pre-edge state, so a pop never frees room for a same-cycle push
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/nic_fifo.sv
// Network interface between a PE and its router port: input/output FIFOs, PE register
// decode, sticky clear-on-read error flags and polarity-gated send.
module nic_fifo
    import nic_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4,
    parameter int VC_BIT    = DATA_W - 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              nicEn,
    input  logic              nicWrEN,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    input  logic              net_si,
    input  logic [DATA_W-1:0] net_di,
    output logic              net_ri,
    input  logic              net_ro,
    input  logic              net_polarity,
    output logic              net_so,
    output logic [DATA_W-1:0] net_do
);

    localparam int IN_CNT_W  = cnt_width(IN_DEPTH);
    localparam int OUT_CNT_W = cnt_width(OUT_DEPTH);

    if (IN_CNT_W > 8 || OUT_CNT_W > 8) begin : g_cnt_width_chk
        $error("nic_fifo: FIFO depth too large for the 8-bit status count field");
    end
    if (DATA_W <= STAT_ERR1 || VC_BIT >= DATA_W || VC_BIT < 0) begin : g_width_chk
        $error("nic_fifo: DATA_W too narrow for status word or VC_BIT out of range");
    end

    logic [DATA_W-1:0]    in_head, out_head;
    logic                 in_full, in_empty, out_full, out_empty;
    logic [IN_CNT_W-1:0]  in_count;
    logic [OUT_CNT_W-1:0] out_count;
    logic                 in_ovf, in_udf, out_ovf;
    logic                 pe_rd, pe_wr, rd_in_data, rd_in_stat, rd_out_stat, wr_out_data;
    logic                 in_pop, out_push, send;
    logic [DATA_W-1:0]    in_stat, out_stat;

    assign pe_rd       = nicEn && !nicWrEN;
    assign pe_wr       = nicEn && nicWrEN;
    assign rd_in_data  = pe_rd && (addr == ADDR_IN_DATA);
    assign rd_in_stat  = pe_rd && (addr == ADDR_IN_STAT);
    assign rd_out_stat = pe_rd && (addr == ADDR_OUT_STAT);
    assign wr_out_data = pe_wr && (addr == ADDR_OUT_DATA);

    assign in_pop   = rd_in_data && !in_empty;
    assign out_push = wr_out_data && !out_full;

    // A head with the wrong VC polarity stalls the whole output queue
    assign send   = !out_empty && net_ro && (out_head[VC_BIT] == net_polarity);
    assign net_so = send;
    assign net_do = send ? out_head : '0;
    assign net_ri = reset && !in_full;

    nic_sync_fifo #(.W(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (net_si),
        .pop   (in_pop),
        .wdata (net_di),
        .rdata (in_head),
        .full  (in_full),
        .empty (in_empty),
        .count (in_count)
    );

    nic_sync_fifo #(.W(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (out_push),
        .pop   (send),
        .wdata (d_in),
        .rdata (out_head),
        .full  (out_full),
        .empty (out_empty),
        .count (out_count)
    );

    always_comb begin
        in_stat                             = '0;
        in_stat[STAT_FLAG0]                 = !in_empty;
        in_stat[STAT_FLAG1]                 = in_full;
        in_stat[STAT_CNT_LSB +: IN_CNT_W]   = in_count;
        in_stat[STAT_ERR0]                  = in_ovf;
        in_stat[STAT_ERR1]                  = in_udf;
    end

    always_comb begin
        out_stat                            = '0;
        out_stat[STAT_FLAG0]                = out_full;
        out_stat[STAT_FLAG1]                = out_empty;
        out_stat[STAT_CNT_LSB +: OUT_CNT_W] = out_count;
        out_stat[STAT_ERR0]                 = out_ovf;
    end

    // A new error event in the same cycle as the clearing status read keeps the flag set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ovf  <= 1'b0;
            in_udf  <= 1'b0;
            out_ovf <= 1'b0;
        end else begin
            in_ovf  <= (net_si && in_full) || (in_ovf && !rd_in_stat);
            in_udf  <= (rd_in_data && in_empty) || (in_udf && !rd_in_stat);
            out_ovf <= (wr_out_data && out_full) || (out_ovf && !rd_out_stat);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_out <= '0;
        end else if (pe_rd) begin
            case (nic_addr_e'(addr))
                ADDR_IN_DATA:  d_out <= in_empty ? '0 : in_head;
                ADDR_IN_STAT:  d_out <= in_stat;
                ADDR_OUT_STAT: d_out <= out_stat;
                default:       d_out <= d_out;
            endcase
        end
    end

endmodule
